blit_loop_ctl: RTL and testbench

- Two-level loop sequencer (inner pixel count, outer line count) for the blitter datapath.
- Issues per-element step requests and waits for the datapath ack on each one.
- Decrements both counters; terminates on 16-bit zero detection of the counter values.
- Sits between the blitter command registers and the address/data pipeline; also provides the end-of-line strobe for address update.

---
 rtl/blit_pkg.sv | 21 ++
 rtl/cnt_zd.sv | 61 ++++++
 rtl/blit_loop_ctl.sv | 172 +++++++++++++++++
 tb/tb_blit_loop_ctl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// ----------------------------------------------------------------------------
// blit_pkg
// Shared types and constants for the blitter loop sequencer.
//   state_t  : sequencer states (IDLE, INNER, LINE, DONE)
//   CW_DEF   : default counter width; must be a multiple of 4 because the
//              zero detect is assembled from 4-bit NOR groups
//   STALL_W  : width of the optional stall counter (BLIT_LOOP_STALL_CNT_EN)
// ----------------------------------------------------------------------------
package blit_pkg;

    localparam int CW_DEF  = 16;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INNER = 2'd1,
        LINE  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_zd.sv
// ----------------------------------------------------------------------------
// cnt_zd
// Loadable CW-bit down-counter with zero detection.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (count -> 0)
//   i_ld          : load i_ld_val (has priority over i_dec)
//   i_ld_val      : value to load
//   i_dec         : decrement by one
//   o_cnt         : current count
//   o_next_zero   : count minus one is zero (i.e. the next decrement ends it)
//   o_ld_zero     : load value is zero
// Zero detect is a set of 4-bit NOR groups ANDed together, so CW must be a
// multiple of 4.
// ----------------------------------------------------------------------------
module cnt_zd #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ld,
    input  logic [CW-1:0] i_ld_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_next_zero,
    output logic          o_ld_zero
);

    localparam int NG = CW / 4;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_dec_val;
    logic [NG-1:0] w_nz_grp;
    logic [NG-1:0] w_lz_grp;

    assign w_dec_val = r_cnt - {{(CW-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_zd
            assign w_nz_grp[gi] = ~|w_dec_val[4*gi +: 4];
            assign w_lz_grp[gi] = ~|i_ld_val[4*gi +: 4];
        end
    endgenerate

    // The decrement is never issued at zero, so the wrapped value of
    // w_dec_val for r_cnt==0 is never acted on.
    assign o_next_zero = &w_nz_grp;
    assign o_ld_zero   = &w_lz_grp;
    assign o_cnt       = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_dec) begin
            r_cnt <= w_dec_val;
        end
    end

endmodule

// File: rtl/blit_loop_ctl.sv
// ----------------------------------------------------------------------------
// blit_loop_ctl
// Two-level loop sequencer for the blitter: inner pixel count, outer line
// count. Issues one step_req per element, waits for step_ack, strobes
// line_end after each line and done at the end of the blit.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : command pulse, accepted only in IDLE
//   abort               : end the blit early (INNER/LINE only), counters freeze
//   inner_ld, outer_ld  : inner (pixels) and outer (lines) load values
//   step_ack            : datapath consumed the current element
//   busy                : blit in progress (through the DONE cycle)
//   step_req            : element request, high throughout INNER
//   line_end            : one-cycle strobe per line (LINE state)
//   done                : one-cycle completion strobe (DONE state)
//   inner_rem, outer_rem: live counter values
//   stall_cnt           : only with BLIT_LOOP_STALL_CNT_EN defined; counts
//                         INNER cycles without ack, saturating
// ----------------------------------------------------------------------------
module blit_loop_ctl
    import blit_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] inner_ld,
    input  logic [CW-1:0] outer_ld,
    input  logic          step_ack,
    output logic          busy,
    output logic          step_req,
    output logic          line_end,
    output logic          done,
    output logic [CW-1:0] inner_rem,
    output logic [CW-1:0] outer_rem
`ifdef BLIT_LOOP_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    state_t r_state;
    state_t w_state_next;

    logic w_inner_ld;
    logic w_inner_dec;
    logic w_outer_ld;
    logic w_outer_dec;
    logic w_inner_next_zero;
    logic w_outer_next_zero;
    logic w_inner_ld_zero;
    logic w_outer_ld_zero;

    cnt_zd #(.CW(CW)) u_inner (
        .clk         (clk),
        .rst         (reset),
        .i_ld        (w_inner_ld),
        .i_ld_val    (inner_ld),
        .i_dec       (w_inner_dec),
        .o_cnt       (inner_rem),
        .o_next_zero (w_inner_next_zero),
        .o_ld_zero   (w_inner_ld_zero)
    );

    cnt_zd #(.CW(CW)) u_outer (
        .clk         (clk),
        .rst         (reset),
        .i_ld        (w_outer_ld),
        .i_ld_val    (outer_ld),
        .i_dec       (w_outer_dec),
        .o_cnt       (outer_rem),
        .o_next_zero (w_outer_next_zero),
        .o_ld_zero   (w_outer_ld_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_inner_ld   = 1'b0;
        w_inner_dec  = 1'b0;
        w_outer_ld   = 1'b0;
        w_outer_dec  = 1'b0;
        busy         = 1'b1;
        step_req     = 1'b0;
        line_end     = 1'b0;
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                // start wins over a simultaneous abort: abort is not looked at here
                if (start) begin
                    w_inner_ld = 1'b1;
                    w_outer_ld = 1'b1;
                    if (w_inner_ld_zero || w_outer_ld_zero) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = INNER;
                    end
                end
            end

            INNER: begin
                step_req = 1'b1;
                // abort beats an ack in the same cycle so the count freezes
                if (abort) begin
                    w_state_next = DONE;
                end else if (step_ack) begin
                    w_inner_dec = 1'b1;
                    if (w_inner_next_zero) begin
                        w_state_next = LINE;
                    end
                end
            end

            LINE: begin
                line_end = 1'b1;
                if (abort) begin
                    w_state_next = DONE;
                end else begin
                    w_outer_dec = 1'b1;
                    if (w_outer_next_zero) begin
                        w_state_next = DONE;
                    end else begin
                        w_inner_ld   = 1'b1;
                        w_state_next = INNER;
                    end
                end
            end

            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef BLIT_LOOP_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall;
    logic               w_stall_clr;
    logic               w_stall_inc;

    assign w_stall_clr = (r_state == IDLE) && start;
    assign w_stall_inc = (r_state == INNER) && !step_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (w_stall_clr) begin
            r_stall <= '0;
        end else if (w_stall_inc && (r_stall != {STALL_W{1'b1}})) begin
            r_stall <= r_stall + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_blit_loop_ctl.sv
// ----------------------------------------------------------------------------
// tb_blit_loop_ctl
// Table-driven bench for blit_loop_ctl: each record holds the inputs for one
// clock and the outputs expected just after that edge. Hand-written sequences
// cover abort-with-ack and asynchronous reset in the middle of a blit.
// ----------------------------------------------------------------------------
module tb_blit_loop_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        step_ack;
    logic [15:0] inner_ld;
    logic [15:0] outer_ld;
    logic        busy;
    logic        step_req;
    logic        line_end;
    logic        done;
    logic [15:0] inner_rem;
    logic [15:0] outer_rem;
`ifdef BLIT_LOOP_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    blit_loop_ctl #(.CW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .inner_ld  (inner_ld),
        .outer_ld  (outer_ld),
        .step_ack  (step_ack),
        .busy      (busy),
        .step_req  (step_req),
        .line_end  (line_end),
        .done      (done),
        .inner_rem (inner_rem),
        .outer_rem (outer_rem)
`ifdef BLIT_LOOP_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        req;
        logic        le;
        logic        done;
        logic [15:0] inner;
        logic [15:0] outer;
    } out_t;

    typedef struct packed {
        logic        start;
        logic        abort;
        logic        ack;
        logic [15:0] ild;
        logic [15:0] old;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic out_t mko(input logic b, input logic r, input logic l,
                                 input logic d, input logic [15:0] i,
                                 input logic [15:0] o);
        out_t t;
        t.busy  = b;
        t.req   = r;
        t.le    = l;
        t.done  = d;
        t.inner = i;
        t.outer = o;
        return t;
    endfunction

    task automatic add(input logic s, input logic a, input logic k,
                       input logic [15:0] il, input logic [15:0] ol,
                       input out_t e);
        vec_t v;
        v.start = s;
        v.abort = a;
        v.ack   = k;
        v.ild   = il;
        v.old   = ol;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t e);
        out_t act;
        act = {busy, step_req, line_end, done, inner_rem, outer_rem};
        n_vec++;
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s: got busy=%b req=%b le=%b done=%b inner=%h outer=%h, want busy=%b req=%b le=%b done=%b inner=%h outer=%h",
                     name, act.busy, act.req, act.le, act.done, act.inner, act.outer,
                     e.busy, e.req, e.le, e.done, e.inner, e.outer);
        end else begin
            $display("ok   %s: busy=%b req=%b le=%b done=%b inner=%h outer=%h",
                     name, act.busy, act.req, act.le, act.done, act.inner, act.outer);
        end
    endtask

`ifdef BLIT_LOOP_STALL_CNT_EN
    task automatic check_stall(input string name, input logic [15:0] e);
        n_vec++;
        if (stall_cnt !== e) begin
            n_miss++;
            $display("FAIL %s: stall_cnt got %0d want %0d", name, stall_cnt, e);
        end else begin
            $display("ok   %s: stall_cnt=%0d", name, stall_cnt);
        end
    endtask
`endif

    // Drive one clock's worth of inputs, then sample just after the edge.
    task automatic cycle(input logic s, input logic a, input logic k,
                         input logic [15:0] il, input logic [15:0] ol);
        start    = s;
        abort    = a;
        step_ack = k;
        inner_ld = il;
        outer_ld = ol;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        step_ack = 1'b0;
        inner_ld = '0;
        outer_ld = '0;
        #2;
        check("reset_state", mko(0, 0, 0, 0, 16'h0, 16'h0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 3 x 2 blit, ack tied high; a start while busy carries junk loads
        add(1, 0, 1, 16'd3, 16'd2, mko(1, 1, 0, 0, 16'd3, 16'd2));
        add(0, 0, 1, 16'd3, 16'd2, mko(1, 1, 0, 0, 16'd2, 16'd2));
        add(1, 0, 1, 16'd7, 16'd7, mko(1, 1, 0, 0, 16'd1, 16'd2));
        add(0, 0, 1, 16'd3, 16'd2, mko(1, 0, 1, 0, 16'd0, 16'd2));
        add(0, 0, 1, 16'd3, 16'd2, mko(1, 1, 0, 0, 16'd3, 16'd1));
        add(0, 0, 1, 16'd3, 16'd2, mko(1, 1, 0, 0, 16'd2, 16'd1));
        add(0, 0, 1, 16'd3, 16'd2, mko(1, 1, 0, 0, 16'd1, 16'd1));
        add(0, 0, 1, 16'd3, 16'd2, mko(1, 0, 1, 0, 16'd0, 16'd1));
        add(0, 0, 1, 16'd3, 16'd2, mko(1, 0, 0, 1, 16'd0, 16'd0));
        add(0, 0, 1, 16'd3, 16'd2, mko(0, 0, 0, 0, 16'd0, 16'd0));
        // abort in IDLE does nothing
        add(0, 1, 1, 16'd3, 16'd2, mko(0, 0, 0, 0, 16'd0, 16'd0));
        // zero inner load goes straight to DONE
        add(1, 0, 0, 16'd0, 16'd5, mko(1, 0, 0, 1, 16'd0, 16'd5));
        add(0, 0, 0, 16'd0, 16'd5, mko(0, 0, 0, 0, 16'd0, 16'd5));
        // start+abort together in IDLE starts; 4 x 1 with alternating ack
        add(1, 1, 0, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd4, 16'd1));
        add(0, 0, 0, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd4, 16'd1));
        add(0, 0, 1, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd3, 16'd1));
        add(0, 0, 0, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd3, 16'd1));
        add(0, 0, 1, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd2, 16'd1));
        add(0, 0, 0, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd2, 16'd1));
        add(0, 0, 1, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd1, 16'd1));
        add(0, 0, 0, 16'd4, 16'd1, mko(1, 1, 0, 0, 16'd1, 16'd1));
        add(0, 0, 1, 16'd4, 16'd1, mko(1, 0, 1, 0, 16'd0, 16'd1));
        add(0, 0, 0, 16'd4, 16'd1, mko(1, 0, 0, 1, 16'd0, 16'd0));
        // abort in DONE has no effect
        add(0, 1, 0, 16'd4, 16'd1, mko(0, 0, 0, 0, 16'd0, 16'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].start, vecs[i].abort, vecs[i].ack, vecs[i].ild, vecs[i].old);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
`ifdef BLIT_LOOP_STALL_CNT_EN
        check_stall("stall_alt_ack", 16'd4);
`endif

        // abort together with the 11th ack: the ack is lost, counters freeze
        cycle(1, 0, 1, 16'hFFFF, 16'd1);
        check("abort_start", mko(1, 1, 0, 0, 16'hFFFF, 16'd1));
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 16'hFFFF, 16'd1);
        end
        check("abort_10acks", mko(1, 1, 0, 0, 16'hFFF5, 16'd1));
        cycle(0, 1, 1, 16'hFFFF, 16'd1);
        check("abort_done", mko(1, 0, 0, 1, 16'hFFF5, 16'd1));
        cycle(0, 0, 0, 16'hFFFF, 16'd1);
        check("abort_idle", mko(0, 0, 0, 0, 16'hFFF5, 16'd1));
`ifdef BLIT_LOOP_STALL_CNT_EN
        check_stall("stall_abort", 16'd0);
`endif

        // asynchronous reset in the middle of INNER
        cycle(1, 0, 1, 16'd5, 16'd2);
        cycle(0, 0, 1, 16'd5, 16'd2);
        check("pre_reset", mko(1, 1, 0, 0, 16'd4, 16'd2));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", mko(0, 0, 0, 0, 16'd0, 16'd0));
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 1, 16'd5, 16'd2);
        check("post_reset_idle", mko(0, 0, 0, 0, 16'd0, 16'd0));
        cycle(1, 0, 1, 16'd1, 16'd1);
        check("one_start", mko(1, 1, 0, 0, 16'd1, 16'd1));
        cycle(0, 0, 1, 16'd1, 16'd1);
        check("one_line", mko(1, 0, 1, 0, 16'd0, 16'd1));
        cycle(0, 0, 1, 16'd1, 16'd1);
        check("one_done", mko(1, 0, 0, 1, 16'd0, 16'd0));
        cycle(0, 0, 1, 16'd1, 16'd1);
        check("one_idle", mko(0, 0, 0, 0, 16'd0, 16'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
